// File: rtl/dport_framer_pkg.sv
// Shared constants for the DisplayPort main-stream framer: K-codes, VB-ID bit
// positions, FSM state encoding and the VB-ID builder.
package dport_framer_pkg;

    localparam logic [7:0] KBS = 8'hBC;
    localparam logic [7:0] KBE = 8'hFB;
    localparam logic [7:0] KFS = 8'hFE;
    localparam logic [7:0] KFE = 8'hF7;

    localparam int VBID_VBLANK    = 0;
    localparam int VBID_FIELD     = 1;
    localparam int VBID_INTERLACE = 2;
    localparam int VBID_NOVIDEO   = 3;
    localparam int VBID_AUDIOMUTE = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BS,
        ST_HDR,
        ST_HBLANK,
        ST_BE,
        ST_ACTIVE,
        ST_FILL
    } state_t;

    // Progressive scan, audio always muted; no-video tracks vertical blank.
    function automatic logic [7:0] vbid(input logic vbl);
        logic [7:0] v;
        v                 = 8'h00;
        v[VBID_AUDIOMUTE] = 1'b1;
        v[VBID_NOVIDEO]   = vbl;
        v[VBID_INTERLACE] = 1'b0;
        v[VBID_FIELD]     = 1'b0;
        v[VBID_VBLANK]    = vbl;
        return v;
    endfunction

endpackage

// File: rtl/dport_framer.sv
// Single-lane DisplayPort main-stream framer: BS, VB-ID/Mvid/Maud header, BE, RGB.
// Optional DPORT_FRAMER_STATS_EN adds ucount (missing pixels) and lcount (active lines).
//
// state     | meaning (symbol currently on sym)
// ST_IDLE   | after reset, D0.0 until the first line strobe
// ST_BS     | BS K-code
// ST_HDR    | header triplet VB-ID / Mvid / Maud, NREP times
// ST_HBLANK | blanking fill before BE
// ST_BE     | BE K-code (active lines only)
// ST_ACTIVE | RGB byte of the current pixel
// ST_FILL   | fill until the next line strobe
module dport_framer
    import dport_framer_pkg::*;
#(
    parameter int NREP = 4,
    parameter int BPP  = 3
) (
    input  logic        dpclk,
    input  logic        reset,
    input  logic        dphstart,
    input  logic        dpvstart,
    input  logic        dpvblank,
    input  logic [15:0] hact,
    input  logic [15:0] blankdly,
    input  logic [7:0]  mvid,
    input  logic [23:0] pxdata,
    input  logic        pxvalid,
    output logic        pxready,
    output logic [7:0]  sym,
    output logic        symk,
    output logic        underflow,
    output logic        lineerr
`ifdef DPORT_FRAMER_STATS_EN
    ,
    output logic [15:0] ucount,
    output logic [15:0] lcount
`endif
);

    localparam int              REPW      = (NREP > 1) ? $clog2(NREP) : 1;
    localparam logic [REPW-1:0] REP_LAST  = REPW'(NREP - 1);
    localparam logic [1:0]      BYTE_LAST = 2'(BPP - 1);

    state_t          state_q, state_d;
    logic [15:0]     cyc_q, cyc_d;
    logic [15:0]     pixcnt_q, pixcnt_d;
    logic [REPW-1:0] rep_q, rep_d;
    logic [1:0]      hsel_q, hsel_d;
    logic [1:0]      bytesel_q, bytesel_d;
    logic            vbl_q, vbl_d;
    logic            line_vbl_q, line_vbl_d;
    logic [7:0]      sym_q, sym_d;
    logic            symk_q, symk_d;
    logic            pxready_q, pxready_d;
    logic            underflow_q, underflow_d;
    logic            lineerr_q, lineerr_d;
    logic            blank_chk, do_sample;
    logic [7:0]      px_byte;

    always_comb begin
        case (bytesel_q)
            2'd0:    px_byte = pxdata[23:16];
            2'd1:    px_byte = pxdata[15:8];
            default: px_byte = pxdata[7:0];
        endcase
    end

    // Next state and the symbol it shows are computed together so BS lands one cycle after dphstart.
    always_comb begin
        state_d     = state_q;
        cyc_d       = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
        pixcnt_d    = pixcnt_q;
        rep_d       = rep_q;
        hsel_d      = hsel_q;
        bytesel_d   = bytesel_q;
        vbl_d       = dpvstart ? 1'b0 : (dpvblank ? 1'b1 : vbl_q);
        line_vbl_d  = line_vbl_q;
        sym_d       = 8'h00;
        symk_d      = 1'b0;
        underflow_d = underflow_q;
        lineerr_d   = lineerr_q;
        blank_chk   = 1'b0;
        do_sample   = 1'b0;

        if (dphstart) begin
            if ((state_q inside {ST_HDR, ST_HBLANK, ST_BE}) ||
                (state_q == ST_ACTIVE && pixcnt_q < hact))
                lineerr_d = 1'b1;
            state_d    = ST_BS;
            sym_d      = KBS;
            symk_d     = 1'b1;
            cyc_d      = 16'd0;
            rep_d      = '0;
            hsel_d     = 2'd0;
            line_vbl_d = vbl_d;
        end else begin
            case (state_q)
                ST_BS: begin
                    state_d = ST_HDR;
                    hsel_d  = 2'd0;
                    rep_d   = '0;
                    sym_d   = vbid(line_vbl_q);
                end
                ST_HDR: begin
                    if (hsel_q == 2'd0) begin
                        hsel_d = 2'd1;
                        sym_d  = mvid;
                    end else if (hsel_q == 2'd1) begin
                        hsel_d = 2'd2;
                    end else if (rep_q != REP_LAST) begin
                        rep_d  = rep_q + REPW'(1);
                        hsel_d = 2'd0;
                        sym_d  = vbid(line_vbl_q);
                    end else begin
                        blank_chk = 1'b1;
                    end
                end
                ST_HBLANK: blank_chk = 1'b1;
                ST_BE: begin
                    if (hact == 16'd0) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d   = ST_ACTIVE;
                        do_sample = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (pixcnt_q >= hact)
                        state_d = ST_FILL;
                    else
                        do_sample = 1'b1;
                end
                default: ;
            endcase

            if (blank_chk) begin
                if (cyc_d < blankdly) begin
                    state_d = ST_HBLANK;
                end else if (line_vbl_q) begin
                    state_d = ST_FILL;
                end else begin
                    state_d   = ST_BE;
                    sym_d     = KBE;
                    symk_d    = 1'b1;
                    bytesel_d = 2'd0;
                    pixcnt_d  = 16'd0;
                end
            end

            if (do_sample) begin
                if (pxvalid)
                    sym_d = px_byte;
                else
                    underflow_d = 1'b1;
                if (bytesel_q == BYTE_LAST) begin
                    bytesel_d = 2'd0;
                    pixcnt_d  = pixcnt_q + 16'd1;
                end else begin
                    bytesel_d = bytesel_q + 2'd1;
                end
            end
        end

        // Ready is held while the last byte is being sampled, so the DMA advances right after it.
        pxready_d = (state_d == ST_ACTIVE) && (bytesel_d == BYTE_LAST);
    end

    always_ff @(posedge dpclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 16'd0;
            pixcnt_q    <= 16'd0;
            rep_q       <= '0;
            hsel_q      <= 2'd0;
            bytesel_q   <= 2'd0;
            vbl_q       <= 1'b1;
            line_vbl_q  <= 1'b1;
            sym_q       <= 8'h00;
            symk_q      <= 1'b0;
            pxready_q   <= 1'b0;
            underflow_q <= 1'b0;
            lineerr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            pixcnt_q    <= pixcnt_d;
            rep_q       <= rep_d;
            hsel_q      <= hsel_d;
            bytesel_q   <= bytesel_d;
            vbl_q       <= vbl_d;
            line_vbl_q  <= line_vbl_d;
            sym_q       <= sym_d;
            symk_q      <= symk_d;
            pxready_q   <= pxready_d;
            underflow_q <= underflow_d;
            lineerr_q   <= lineerr_d;
        end
    end

    assign sym       = sym_q;
    assign symk      = symk_q;
    assign pxready   = pxready_q;
    assign underflow = underflow_q;
    assign lineerr   = lineerr_q;

`ifdef DPORT_FRAMER_STATS_EN
    logic [15:0] ucount_q, lcount_q;
    logic        miss, line_done;

    assign miss      = do_sample && (bytesel_q == BYTE_LAST) && !pxvalid;
    assign line_done = (state_d == ST_FILL) && (state_q inside {ST_BE, ST_ACTIVE});

    always_ff @(posedge dpclk) begin
        if (reset) begin
            ucount_q <= 16'd0;
            lcount_q <= 16'd0;
        end else begin
            if (miss && ucount_q != 16'hFFFF)
                ucount_q <= ucount_q + 16'd1;
            if (line_done)
                lcount_q <= lcount_q + 16'd1;
        end
    end

    assign ucount = ucount_q;
    assign lcount = lcount_q;
`endif

endmodule

// File: tb/tb_dport_framer.sv
// Self-checking bench for dport_framer: table of line scenarios with a symbol scoreboard,
// plus hand sequences for reset. Build with DPORT_FRAMER_STATS_EN to also check counters.
module tb_dport_framer;

    logic        dpclk = 1'b0;
    logic        reset;
    logic        dphstart, dpvstart, dpvblank;
    logic [15:0] hact, blankdly;
    logic [7:0]  mvid;
    logic [23:0] pxdata;
    logic        pxvalid;
    logic        pxready;
    logic [7:0]  sym;
    logic        symk;
    logic        underflow, lineerr;
`ifdef DPORT_FRAMER_STATS_EN
    logic [15:0] ucount, lcount;
`endif

    always #5 dpclk = ~dpclk;

    dport_framer dut (
        .dpclk     (dpclk),
        .reset     (reset),
        .dphstart  (dphstart),
        .dpvstart  (dpvstart),
        .dpvblank  (dpvblank),
        .hact      (hact),
        .blankdly  (blankdly),
        .mvid      (mvid),
        .pxdata    (pxdata),
        .pxvalid   (pxvalid),
        .pxready   (pxready),
        .sym       (sym),
        .symk      (symk),
        .underflow (underflow),
        .lineerr   (lineerr)
`ifdef DPORT_FRAMER_STATS_EN
        ,
        .ucount    (ucount),
        .lcount    (lcount)
`endif
    );

    typedef struct {
        int       hact;
        int       bd;
        logic [7:0] mvid;
        int       pre;       // 0 none, 1 dpvblank pulse the cycle before, 2 dpvstart with dphstart
        bit       vbl;       // expected vertical-blank level of the line
        int       drop;      // pixel index presented with pxvalid=0, -1 for none
        int       abort_at;  // cycle after BS where a new dphstart aborts the line, 0 for none
        bit       uf;
        bit       le;
        int       lc;
        int       uc;
        int       hs;
    } line_t;

    typedef struct {
        logic [7:0] sym;
        logic       k;
        logic       rdy;
    } exp_t;

    exp_t  sb[$];
    line_t tbl[9];
    int    n_vec  = 0;
    int    n_fail = 0;
    int    hs_cnt = 0;
    exp_t  zero_e = '{8'h00, 1'b0, 1'b0};

    function automatic logic [23:0] pixval(input int p);
        return {8'((3 * p + 1) * 17), 8'((3 * p + 2) * 17), 8'((3 * p + 3) * 17)};
    endfunction

    // Expected symbol shown n cycles after the BS edge of a line described by r.
    function automatic exp_t exp_at(input int n, input line_t r);
        exp_t        e;
        int          s;
        logic [23:0] pv;
        e = '{8'h00, 1'b0, 1'b0};
        if (n == 0) begin
            e.sym = 8'hBC;
            e.k   = 1'b1;
        end else if (n <= 12) begin
            case ((n - 1) % 3)
                0:       e.sym = r.vbl ? 8'h19 : 8'h10;
                1:       e.sym = r.mvid;
                default: e.sym = 8'h00;
            endcase
        end else if (n < r.bd) begin
            e.sym = 8'h00;
        end else if (n == r.bd) begin
            if (!r.vbl) begin
                e.sym = 8'hFB;
                e.k   = 1'b1;
            end
        end else if (!r.vbl) begin
            s = n - r.bd - 1;
            if (s < 3 * r.hact) begin
                pv = pixval(s / 3);
                if (s / 3 != r.drop)
                    e.sym = (s % 3 == 0) ? pv[23:16] : ((s % 3 == 1) ? pv[15:8] : pv[7:0]);
                e.rdy = (s % 3 == 1);
            end
        end
        return e;
    endfunction

    task automatic check(input string nm, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, want);
        end
    endtask

    task automatic cycle(input logic dph, input logic vs, input logic vb, input logic rst,
                         input logic [23:0] pd, input logic pv, input exp_t e, input string nm);
        exp_t want;
        @(negedge dpclk);
        dphstart = dph;
        dpvstart = vs;
        dpvblank = vb;
        reset    = rst;
        pxdata   = pd;
        pxvalid  = pv;
        if (pxready && pv)
            hs_cnt++;
        sb.push_back(e);
        @(posedge dpclk);
        #1;
        want = sb.pop_front();
        n_vec++;
        if (sym !== want.sym || symk !== want.k || pxready !== want.rdy) begin
            n_fail++;
            $display("FAIL %s: got sym=%h k=%b rdy=%b, expected sym=%h k=%b rdy=%b",
                     nm, sym, symk, pxready, want.sym, want.k, want.rdy);
        end
    endtask

    task automatic check_flags(input string nm, input line_t r);
        check({nm, " underflow"}, int'(underflow), int'(r.uf));
        check({nm, " lineerr"}, int'(lineerr), int'(r.le));
`ifdef DPORT_FRAMER_STATS_EN
        check({nm, " ucount"}, int'(ucount), r.uc);
        check({nm, " lcount"}, int'(lcount), r.lc);
`endif
    endtask

    task automatic run_line(input line_t r, input string nm);
        int          n, len, ab, s;
        logic [23:0] pd;
        logic        pv, dph, vs;
        bit          started;
        hact     = 16'(r.hact);
        blankdly = 16'(r.bd);
        mvid     = r.mvid;
        hs_cnt   = 0;
        if (r.pre == 1)
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 1'b0, zero_e, {nm, " vblank"});
        ab      = r.abort_at;
        len     = r.bd + 1 + 3 * r.hact + 3;
        n       = 0;
        started = 1'b0;
        while (n < len) begin
            dph = (n == 0);
            if (ab > 0 && n == ab) begin
                n   = 0;
                ab  = 0;
                dph = 1'b1;
            end
            vs      = dph && !started && (r.pre == 2);
            started = 1'b1;
            s       = n - r.bd - 1;
            pd      = 24'h0;
            pv      = 1'b0;
            if (!r.vbl && s >= 0 && s < 3 * r.hact) begin
                pd = pixval(s / 3);
                pv = (s / 3 != r.drop);
            end
            cycle(dph, vs, 1'b0, 1'b0, pd, pv, exp_at(n, r), nm);
            n++;
        end
        check({nm, " handshakes"}, hs_cnt, r.hs);
        check_flags(nm, r);
    endtask

    initial begin
        line_t rst_ln;
        reset    = 1'b1;
        dphstart = 1'b0;
        dpvstart = 1'b0;
        dpvblank = 1'b0;
        hact     = 16'd4;
        blankdly = 16'd20;
        mvid     = 8'h00;
        pxdata   = 24'h0;
        pxvalid  = 1'b0;

        //          hact bd  mvid   pre vbl drop ab  uf le lc uc hs
        tbl[0] = '{4,   20, 8'h5A, 2, 1'b0, -1, 0,  1'b0, 1'b0, 1, 0, 4};
        tbl[1] = '{4,   20, 8'h5A, 1, 1'b1, -1, 0,  1'b0, 1'b0, 1, 0, 0};
        tbl[2] = '{4,   13, 8'h33, 0, 1'b1, -1, 0,  1'b0, 1'b0, 1, 0, 0};
        tbl[3] = '{4,   13, 8'hC3, 2, 1'b0, -1, 0,  1'b0, 1'b0, 2, 0, 4};
        tbl[4] = '{100, 13, 8'h77, 0, 1'b0, -1, 19, 1'b0, 1'b1, 3, 0, 101};
        tbl[5] = '{4,   20, 8'h5A, 0, 1'b0, 2,  0,  1'b1, 1'b1, 4, 1, 3};
        tbl[6] = '{0,   16, 8'h12, 0, 1'b0, -1, 0,  1'b1, 1'b1, 5, 1, 0};
        tbl[7] = '{2,   14, 8'hA5, 0, 1'b0, -1, 0,  1'b1, 1'b1, 6, 1, 2};
        tbl[8] = '{4,   13, 8'h5A, 0, 1'b1, -1, 0,  1'b0, 1'b0, 0, 0, 0};
        rst_ln = '{0, 0, 8'h00, 0, 1'b0, -1, 0, 1'b0, 1'b0, 0, 0, 0};

        // Reset state; a line strobe while reset is high must be ignored.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0, zero_e, "reset");
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0, zero_e, "reset dphstart");
        check_flags("reset", rst_ln);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, zero_e, "idle");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, zero_e, "idle");

        for (int i = 0; i < 8; i++)
            run_line(tbl[i], $sformatf("line%0d", i));

        // Reset in the middle of the header returns to IDLE and clears sticky flags.
        for (int n = 0; n < 4; n++)
            cycle(n == 0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, exp_at(n, tbl[7]), "hdr before reset");
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0, zero_e, "mid-hdr reset");
        check_flags("mid-hdr reset", rst_ln);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0, zero_e, "held reset dphstart");
        for (int n = 0; n < 3; n++)
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, zero_e, "idle after reset");

        // vbl comes out of reset set, so this line is a blanking line.
        run_line(tbl[8], "line after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
